unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter that lets the pipelined RISC-V core's instruction-fetch port and data port share one single-port synchronous memory with one-cycle read latency. It sits between the core and the memory macro, grants at most one access per cycle, and routes returned read data to the requester that issued the read. Data accesses have priority; a starvation counter bounds how long fetch can be held off. The core sees a lost arbitration as a not-granted request and stalls on it.

## Interface
- P_DATA_WIDTH, 32, data word width
- P_ADDR_WIDTH, 11, memory word-address width
- P_STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; held with stable address until granted
- i_if_addr  in  P_ADDR_WIDTH  fetch word address
- o_if_gnt  out  1  fetch accepted this cycle (combinational)
- o_if_rvalid  out  1  o_if_rdata valid (registered)
- o_if_rdata  out  P_DATA_WIDTH  fetched instruction
- i_d_req  in  1  data request; held stable until granted
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  P_ADDR_WIDTH  data word address
- i_d_wdata  in  P_DATA_WIDTH  store data
- i_d_storetype  in  3  store type, passed to memory unchanged
- o_d_gnt  out  1  data accepted this cycle (combinational)
- o_d_rvalid  out  1  o_d_rdata valid (registered, loads only)
- o_d_rdata  out  P_DATA_WIDTH  load data
- o_mem_en  out  1  memory access this cycle
- o_mem_we  out  1  memory write
- o_mem_addr  out  P_ADDR_WIDTH  memory address
- o_mem_wdata  out  P_DATA_WIDTH  memory write data
- o_mem_storetype  out  3  memory store type
- i_mem_rdata  in  P_DATA_WIDTH  read data, valid the cycle after a read enable

## Operation
- Winner per cycle: if only one requester is active, it wins. If both are active, data wins unless starve_cnt == P_STARVE_LIMIT, in which case fetch wins.
- starve_cnt is 4 bits. It increments, saturating at P_STARVE_LIMIT, on each cycle with i_if_req=1 and o_if_gnt=0. It clears to 0 on any cycle with o_if_gnt=1 or i_if_req=0.
- Winner's grant is asserted in the same cycle, and the memory is driven with the winner's fields:
  - fetch: we=0, wdata=0, storetype=0
  - data: i_d_we, i_d_wdata, i_d_storetype passed through
- o_mem_en = o_if_gnt | o_d_gnt. When idle, all o_mem_* outputs are 0.
- Read owner register rd_owner ∈ {NONE, IF, D}, updated every cycle:
  - IF after a fetch grant
  - D after a data grant with we=0
  - NONE otherwise, including after data stores
- o_if_rvalid = (rd_owner==IF); o_d_rvalid = (rd_owner==D).
- o_if_rdata and o_d_rdata both carry i_mem_rdata unconditionally. Consumers qualify with rvalid.
- Grants are pure functions of the current requests plus starve_cnt. A requester that drops req before it is granted is simply not served; no state is held for it.
- Reset: starve_cnt=0, rd_owner=NONE. While i_rst=1, both grants and o_mem_en are forced to 0. A read in flight when reset asserts is discarded, so no rvalid follows.

## Timing
- Reset values: o_if_gnt=0, o_d_gnt=0, o_if_rvalid=0, o_d_rvalid=0, all o_mem_*=0. rdata outputs follow i_mem_rdata.
- Grant latency is 0 cycles: request to grant in the same cycle.
- Read data latency is 1 cycle: grant in cycle N, rvalid and rdata in cycle N+1.
- Full throughput is one access per cycle. Back-to-back reads from alternating owners return in issue order, each exactly one cycle after its grant.
- Stores complete at the clock edge of the grant cycle; no response is returned.
- Worst-case fetch wait under continuous data traffic is P_STARVE_LIMIT denied cycles; fetch is granted on the next cycle.
- Simultaneous events:
  - Data read granted in cycle N and fetch granted in N+1: o_d_rvalid in N+1, o_if_rvalid in N+2. The two rvalids are never high in the same cycle.
  - Reset in cycle N clears any rvalid due in N+1.

## Test plan
- Fetch only, addresses 0,1,2 on consecutive cycles, memory preloaded with mem[k]=0x100+k → o_if_gnt=1 each cycle; o_if_rvalid=1 for 3 cycles with rdata 0x100, 0x101, 0x102, each lagging its grant by 1 cycle.
- Both requesting, data load to addr 0x40 (mem=0xDEADBEEF) while fetch addr 0x10 → o_d_gnt=1, o_if_gnt=0; next cycle o_d_rvalid=1 with rdata 0xDEADBEEF, o_if_rvalid=0; fetch granted in the following cycle.
- Continuous data requests plus fetch held, P_STARVE_LIMIT=4 → data granted in cycles 0–3, fetch granted in cycle 4; starve_cnt=0 after; data granted again in cycle 5.
- Data store addr 0x20, wdata 0x12345678, storetype 3'b010 → o_mem_en=1, o_mem_we=1 with fields passed through; no rvalid next cycle. A later load of 0x20 returns 0x12345678.
- Alternating data read and fetch every cycle for 8 cycles → each rvalid goes to the correct owner, one cycle after its grant; the two rvalids are never high together.
- Assert i_rst in the cycle after a fetch grant → o_if_rvalid=0 in that cycle and after; grants and o_mem_en stay 0 while reset is held; normal arbitration resumes in the first cycle after reset deasserts.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous memory (1-cycle read latency) between the
// instruction-fetch and data ports of the core; data has priority, fetch is starvation-bounded.
module unified_mem_arbiter #(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_ADDR_WIDTH   = 11,
  parameter int P_STARVE_LIMIT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_if_req,
  input  logic [P_ADDR_WIDTH-1:0] i_if_addr,
  output logic                    o_if_gnt,
  output logic                    o_if_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_if_rdata,
  input  logic                    i_d_req,
  input  logic                    i_d_we,
  input  logic [P_ADDR_WIDTH-1:0] i_d_addr,
  input  logic [P_DATA_WIDTH-1:0] i_d_wdata,
  input  logic [2:0]              i_d_storetype,
  output logic                    o_d_gnt,
  output logic                    o_d_rvalid,
  output logic [P_DATA_WIDTH-1:0] o_d_rdata,
  output logic                    o_mem_en,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  output logic [2:0]              o_mem_storetype,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

  // Handshake: a request (i_*_req) is accepted in the same cycle its grant is
  // high; an ungranted request is simply not served and must be re-presented.
  // Read responses are flagged by a one-cycle rvalid pulse on the owning port.

  localparam logic [3:0] LP_LIMIT = 4'(P_STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t     r_rd_owner;
  owner_t     w_rd_owner_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_if_win;
  logic       w_d_win;
  logic       w_fetch_forced;

  assign w_fetch_forced = (r_starve_cnt == LP_LIMIT);

  // Winner selection; reset suppresses every grant.
  always_comb begin
    w_if_win = 1'b0;
    w_d_win  = 1'b0;
    if (!i_rst) begin
      if (i_if_req && i_d_req) begin
        if (w_fetch_forced) w_if_win = 1'b1;
        else                w_d_win  = 1'b1;
      end else if (i_if_req) begin
        w_if_win = 1'b1;
      end else if (i_d_req) begin
        w_d_win = 1'b1;
      end
    end
  end

  assign o_if_gnt = w_if_win;
  assign o_d_gnt  = w_d_win;

  // Memory port mux; all fields forced to zero when idle.
  always_comb begin
    o_mem_en        = 1'b0;
    o_mem_we        = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    o_mem_storetype = 3'b000;
    if (w_if_win) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
    end else if (w_d_win) begin
      o_mem_en        = 1'b1;
      o_mem_we        = i_d_we;
      o_mem_addr      = i_d_addr;
      o_mem_wdata     = i_d_wdata;
      o_mem_storetype = i_d_storetype;
    end
  end

  // Next read owner: tracks who issued the read whose data returns next cycle.
  always_comb begin
    w_rd_owner_nxt = OWN_NONE;
    if (w_if_win)                w_rd_owner_nxt = OWN_IF;
    else if (w_d_win && !i_d_we) w_rd_owner_nxt = OWN_D;
  end

  always_comb begin
    w_starve_nxt = 4'd0;
    if (i_if_req && !w_if_win) begin
      if (r_starve_cnt >= LP_LIMIT) w_starve_nxt = LP_LIMIT;
      else                          w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_owner   <= OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_rd_owner   <= w_rd_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Gating with i_rst drops a response that would land in the reset cycle itself.
  assign o_if_rvalid = (r_rd_owner == OWN_IF) && !i_rst;
  assign o_d_rvalid  = (r_rd_owner == OWN_D)  && !i_rst;
  assign o_if_rdata  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed phases from the test plan plus random
// traffic, checked against a priority/starvation reference model and a shadow memory.
module tb_unified_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int LIMIT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt, o_if_rvalid;
  logic [DW-1:0] o_if_rdata;
  logic          i_d_req, i_d_we;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic [2:0]    i_d_storetype;
  logic          o_d_gnt, o_d_rvalid;
  logic [DW-1:0] o_d_rdata;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [2:0]    o_mem_storetype;
  logic [DW-1:0] i_mem_rdata;

  always #5 i_clk = ~i_clk;

  unified_mem_arbiter #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_storetype(i_d_storetype),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_storetype(o_mem_storetype),
    .i_mem_rdata(i_mem_rdata)
  );

  // Memory macro driven by the DUT's memory port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= mem[o_mem_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q[$];     // {is_data_port, data}
  int            due_q[$];     // cycle in which the response is expected
  int            m_denied;     // consecutive denied fetch cycles
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge i_clk) begin
    logic          e_if_rv, e_d_rv, m_if_win, m_d_win;
    logic [DW:0]   e;
    logic [DW-1:0] e_data;
    if (i_rst) begin
      chk("rst_if_gnt", 64'(o_if_gnt), 64'd0);
      chk("rst_d_gnt", 64'(o_d_gnt), 64'd0);
      chk("rst_mem_en", 64'(o_mem_en), 64'd0);
      chk("rst_mem_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_storetype}, 64'd0);
      chk("rst_if_rvalid", 64'(o_if_rvalid), 64'd0);
      chk("rst_d_rvalid", 64'(o_d_rvalid), 64'd0);
      exp_q.delete();
      due_q.delete();
      m_denied = 0;
    end else begin
      e_if_rv = 1'b0;
      e_d_rv  = 1'b0;
      e_data  = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        e_data = e[DW-1:0];
        if (e[DW]) e_d_rv = 1'b1;
        else       e_if_rv = 1'b1;
      end
      chk("if_rvalid", 64'(o_if_rvalid), 64'(e_if_rv));
      chk("d_rvalid", 64'(o_d_rvalid), 64'(e_d_rv));
      if (e_if_rv) chk("if_rdata", 64'(o_if_rdata), 64'(e_data));
      if (e_d_rv)  chk("d_rdata", 64'(o_d_rdata), 64'(e_data));

      // Data has priority unless fetch has been denied LIMIT cycles in a row.
      m_if_win = i_if_req && (!i_d_req || m_denied >= LIMIT);
      m_d_win  = i_d_req && !m_if_win;
      chk("if_gnt", 64'(o_if_gnt), 64'(m_if_win));
      chk("d_gnt", 64'(o_d_gnt), 64'(m_d_win));
      chk("mem_en", 64'(o_mem_en), 64'(m_if_win || m_d_win));
      if (m_if_win) begin
        chk("mem_if_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_storetype},
            {1'b0, i_if_addr, 32'd0, 3'd0});
        exp_q.push_back({1'b0, ref_mem[i_if_addr]});
        due_q.push_back(cyc + 1);
      end else if (m_d_win) begin
        chk("mem_d_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_storetype},
            {i_d_we, i_d_addr, i_d_wdata, i_d_storetype});
        if (i_d_we) begin
          ref_mem[i_d_addr] = i_d_wdata;
        end else begin
          exp_q.push_back({1'b1, ref_mem[i_d_addr]});
          due_q.push_back(cyc + 1);
        end
      end else begin
        chk("mem_idle_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_storetype}, 64'd0);
      end
      if (i_if_req && !m_if_win) m_denied = (m_denied >= LIMIT) ? LIMIT : m_denied + 1;
      else                       m_denied = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic ifr, input logic [AW-1:0] ifa,
                       input logic dr, input logic dwe, input logic [AW-1:0] da,
                       input logic [DW-1:0] dwd, input logic [2:0] st);
    i_rst         = rst;
    i_if_req      = ifr;
    i_if_addr     = ifa;
    i_d_req       = dr;
    i_d_we        = dwe;
    i_d_addr      = da;
    i_d_wdata     = dwd;
    i_d_storetype = st;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'd0);
  endtask

  initial begin
    logic [DW-1:0] v;
    m_denied = 0;
    for (int k = 0; k < (1 << AW); k++) begin
      v = $urandom;
      mem[k] = v;
      ref_mem[k] = v;
    end
    for (int k = 0; k < 3; k++) begin
      mem[k] = 32'h100 + k;
      ref_mem[k] = 32'h100 + k;
    end
    mem[11'h40]     = 32'hDEADBEEF;
    ref_mem[11'h40] = 32'hDEADBEEF;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 3'd0);
    idle(1);

    // Fetch-only burst 0,1,2
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, AW'(k), 1'b0, 1'b0, '0, '0, 3'd0);
    idle(2);

    // Contention: data load 0x40 wins, fetch 0x10 follows
    drive(1'b0, 1'b1, 11'h10, 1'b1, 1'b0, 11'h40, '0, 3'd0);
    drive(1'b0, 1'b1, 11'h10, 1'b0, 1'b0, '0, '0, 3'd0);
    idle(2);

    // Starvation: continuous data loads, fetch held
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 11'h5, 1'b1, 1'b0, AW'(11'h60 + i), '0, 3'd0);
    idle(2);

    // Store then load back
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 11'h20, 32'h12345678, 3'b010);
    idle(1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 11'h20, '0, 3'd0);
    idle(2);

    // Alternating data read / fetch
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b0, '0, 1'b1, 1'b0, AW'(i), '0, 3'd0);
      else            drive(1'b0, 1'b1, AW'(11'h30 + i), 1'b0, 1'b0, '0, '0, 3'd0);
    end
    idle(2);

    // Reset right after a fetch grant drops the pending response
    drive(1'b0, 1'b1, 11'h7, 1'b0, 1'b0, '0, '0, 3'd0);
    drive(1'b1, 1'b1, 11'h8, 1'b1, 1'b0, 11'h9, '0, 3'd0);
    drive(1'b1, 1'b1, 11'h8, 1'b1, 1'b0, 11'h9, '0, 3'd0);
    drive(1'b0, 1'b1, 11'h8, 1'b1, 1'b0, 11'h9, '0, 3'd0);
    idle(2);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 63)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 63)), $urandom, 3'($urandom_range(0, 7)));
    end
    idle(4);

    chk("drain_empty", 64'(due_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
